uart_tx_unit: RTL and testbench
===============================

Name: uart_tx_unit

Overview:
- UART transmit path: the other end of the line from the team's UART receiver.
- Contains a baud tick generator, a 2^ADDR_WIDTH-deep write FIFO and a 16x-oversampled serialiser FSM.
- The host pushes bytes with wr_uart.
- The block sends each byte LSB-first on tx, framed as 1 start bit, DBIT data bits, then a stop period of SB_TICK ticks.
- tx_done_tick pulses once per frame.

Parameters:
- DBIT, 8, number of data bits per frame (1..8).
- SB_TICK, 16, length of the stop period in baud ticks (16 = 1 stop bit, 32 = 2 stop bits).
- DATA_WIDTH, 8, FIFO word width; must be >= DBIT.
- ADDR_WIDTH, 2, FIFO address width; depth is 2^ADDR_WIDTH = 4.

Ports:
- clk  in  1  system clock, 100 MHz nominal.
- reset  in  1  asynchronous, active-low reset.
- dvsr  in  11  baud divisor; one tick every dvsr+1 clk cycles.
- wr_uart  in  1  push w_data into the FIFO (one word per cycle while high).
- w_data  in  DATA_WIDTH  byte to send; bits [DBIT-1:0] are used.
- tx_full  out  1  FIFO full.
- tx_empty  out  1  FIFO empty.
- tx  out  1  serial line, idle high.
- tx_done_tick  out  1  one-clk pulse at the end of the stop period.

Behaviour:
- Reset (reset=0, asynchronous), all taking effect immediately:
  - tx=1, tx_done_tick=0, tx_full=0, tx_empty=1.
  - FSM forced to idle; FIFO pointers cleared.
  - Baud counter=0; s, n and b_reg cleared.
- Reset asserted mid-frame: the frame is aborted, tx returns to 1 and queued bytes are lost.
- Baud generator:
  - Free-running 11-bit counter.
  - When counter >= dvsr: next counter=0 and tick=1 for that cycle; otherwise increment.
  - dvsr=650 gives a tick every 651 clk, i.e. 16 ticks/bit, about 9600 baud.
  - dvsr=0 gives a tick every cycle.
  - A change to dvsr takes effect without counter overrun, because the compare is >=.
- FIFO:
  - Registered write: wr_uart && !tx_full stores w_data at the write pointer.
  - A write while full is dropped silently, with no state change.
  - A pop is issued only by the FSM; no pop occurs while empty.
  - Pointers wrap modulo depth.
  - Simultaneous push and pop while full: both take effect and tx_full stays 1.
  - tx_full and tx_empty are registered flags, updated on the clk edge after the push or pop.
- FSM: states idle, start, data, stop; tx is driven from a register (glitch-free).
  - idle: tx=1. If !tx_empty: load b_reg with the FIFO head, pop, set s=0, go to start.
  - start: tx=0. On each tick: if s==15 then s=0, n=0, go to data; otherwise s++.
  - data: tx=b_reg[0]. On each tick: if s==15 then s=0, b_reg>>=1, and either go to stop (n==DBIT-1) or n++; otherwise s++.
  - stop: tx=1. On each tick: if s==SB_TICK-1 then tx_done_tick=1 for one clk and go to idle; otherwise s++.
- Frame timing:
  - The start bit's falling edge is 1 clk after the load.
  - Its length is between 15 and 16 tick periods, because the baud counter is free-running.
  - Every later bit boundary coincides with a tick.
- Back-to-back frames:
  - If the FIFO is not empty when stop ends, idle reloads on the next clk.
  - Inter-frame gap is 1 clk (tx stays 1).
- A host write that lands on an empty FIFO is visible to idle 1 clk later, so the first frame starts 2 clk after the wr_uart edge.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- When defined:
  - Adds a parity state between data and stop, lasting 16 ticks with tx = even parity (XOR of the DBIT data bits).
  - data goes to parity instead of stop; parity goes to stop.
  - Parity is computed at load time and held in a register.
- When undefined: four states only; a frame is start + DBIT + stop with no parity bit.

Test Plan:
- Reset/idle: hold reset=0 for 3 clk, then release with no writes → tx=1, tx_empty=1, tx_full=0, tx_done_tick=0 for 10k clk.
- Single byte: dvsr=650, write 8'b01111110 → tx samples at the bit centres (16 ticks/bit) decode as 0,0,1,1,1,1,1,1,0,1; exactly one tx_done_tick; tx_empty returns to 1.
- FIFO fill and drop: dvsr=650, write 0x7E, 0xFF, 0x81, 0xAA, 0x55, 0x33 on consecutive clk.
  - 0x7E is popped at once; tx_full rises after 0x55.
  - 0x33 is dropped.
  - Line carries 0x7E, 0xFF, 0x81, 0xAA, 0x55, each separated by a 1-clk gap; five done ticks.
- Reset mid-frame: dvsr=10, write 0xA5, assert reset in the 4th data bit → tx=1 in the same cycle; state idle, FIFO empty; no done tick.
- Fast divisor: dvsr=0, write 0x81 → frame is 160 clk (±1 on start); done tick after about 161 clk; bits match.
- Parity (UART_TX_PARITY_EN): write 0x07 → parity bit=1; write 0x03 → parity bit=0; frame has 11 bit periods.

Source files
------------

// File: rtl/uart_tx_unit.sv
// rtl/uart_tx_unit.sv - UART transmitter: baud tick generator, write FIFO and 16x serialiser
// Optional even-parity bit between data and stop when UART_TX_PARITY_EN is defined.
module uart_tx_unit #(
  parameter int DBIT       = 8,
  parameter int SB_TICK    = 16,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [10:0]           dvsr,
  input  logic                  wr_uart,
  input  logic [DATA_WIDTH-1:0] w_data,
  output logic                  tx_full,
  output logic                  tx_empty,
  output logic                  tx,
  output logic                  tx_done_tick
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int SW    = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam int NW    = (DBIT > 1) ? $clog2(DBIT) : 1;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;
  logic par_q;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;
`endif

  state_t          state_q;
  logic [SW-1:0]   s_q;
  logic [NW-1:0]   n_q;
  logic [DBIT-1:0] b_q;
  logic            tx_q;
  logic            done_q;

  // Baud generator: >= compare keeps a shrinking dvsr from overrunning the counter
  logic [10:0] cnt_q, cnt_d;
  logic        tick;

  always_comb begin
    tick  = (cnt_q >= dvsr);
    cnt_d = tick ? 11'd0 : cnt_q + 11'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= 11'd0;
    else        cnt_q <= cnt_d;
  end

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                  full_q, full_d, empty_q, empty_d;
  logic                  push, pop;
  logic [DATA_WIDTH-1:0] rd_data;

  // A pop frees a slot in the same cycle, so a push while full is accepted alongside it
  assign pop     = (state_q == ST_IDLE) && !empty_q;
  assign push    = wr_uart && (!full_q || pop);
  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    full_d   = full_q;
    empty_d  = empty_q;
    if (push) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
    if (push && !pop) begin
      empty_d = 1'b0;
      full_d  = (wr_ptr_d == rd_ptr_q);
    end else if (pop && !push) begin
      full_d  = 1'b0;
      empty_d = (rd_ptr_d == wr_ptr_q);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= w_data;
  end

  // tx is registered from the current state, so the line trails state changes by one clk
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          tx_q <= 1'b1;
          if (!empty_q) begin
            b_q     <= rd_data[DBIT-1:0];
            s_q     <= '0;
            state_q <= ST_START;
`ifdef UART_TX_PARITY_EN
            par_q   <= ^rd_data[DBIT-1:0];
`endif
          end
        end
        ST_START: begin
          tx_q <= 1'b0;
          if (tick) begin
            if (s_q == SW'(15)) begin
              s_q     <= '0;
              n_q     <= '0;
              state_q <= ST_DATA;
            end else begin
              s_q <= s_q + SW'(1);
            end
          end
        end
        ST_DATA: begin
          tx_q <= b_q[0];
          if (tick) begin
            if (s_q == SW'(15)) begin
              s_q <= '0;
              b_q <= b_q >> 1;
              if (n_q == NW'(DBIT - 1)) begin
`ifdef UART_TX_PARITY_EN
                state_q <= ST_PARITY;
`else
                state_q <= ST_STOP;
`endif
              end else begin
                n_q <= n_q + NW'(1);
              end
            end else begin
              s_q <= s_q + SW'(1);
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          tx_q <= par_q;
          if (tick) begin
            if (s_q == SW'(15)) begin
              s_q     <= '0;
              state_q <= ST_STOP;
            end else begin
              s_q <= s_q + SW'(1);
            end
          end
        end
`endif
        ST_STOP: begin
          tx_q <= 1'b1;
          if (tick) begin
            if (s_q == SW'(SB_TICK - 1)) begin
              done_q  <= 1'b1;
              state_q <= ST_IDLE;
            end else begin
              s_q <= s_q + SW'(1);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign tx           = tx_q;
  assign tx_done_tick = done_q;
  assign tx_full      = full_q;
  assign tx_empty     = empty_q;

endmodule

// File: tb/tb_uart_tx_unit.sv
// tb/tb_uart_tx_unit.sv - scoreboard bench for uart_tx_unit with a bit-centre line decoder
module tb_uart_tx_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] dvsr = 11'd0;
  logic        wr_uart = 1'b0;
  logic [7:0]  w_data = 8'h00;
  logic        tx_full, tx_empty, tx, tx_done_tick;

  int         n_checks = 0;
  int         n_errors = 0;
  int         done_cnt = 0;
  int         cycle_cnt = 0;
  logic [7:0] exp_q[$];

  uart_tx_unit dut (
    .clk          (clk),
    .reset        (reset),
    .dvsr         (dvsr),
    .wr_uart      (wr_uart),
    .w_data       (w_data),
    .tx_full      (tx_full),
    .tx_empty     (tx_empty),
    .tx           (tx),
    .tx_done_tick (tx_done_tick)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle_cnt++;
  always @(negedge clk) if (tx_done_tick === 1'b1) done_cnt++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic recv_frame(input int bit_clk, output logic [7:0] d, output logic p, output bit ok);
    int t;
    ok = 1'b0;
    d  = 8'h00;
    p  = 1'b0;
    t  = 0;
    while (tx !== 1'b0 && t < 4 * bit_clk + 100) begin
      @(negedge clk);
      t++;
    end
    if (tx !== 1'b0) begin
      check("rx_start_seen", 32'(tx === 1'b0), 32'd1);
      return;
    end
    repeat (bit_clk / 2) @(negedge clk);
    check("rx_start_bit", 32'(tx), 32'd0);
    for (int i = 0; i < 8; i++) begin
      repeat (bit_clk) @(negedge clk);
      d[i] = tx;
    end
`ifdef UART_TX_PARITY_EN
    repeat (bit_clk) @(negedge clk);
    p = tx;
`endif
    repeat (bit_clk) @(negedge clk);
    check("rx_stop_bit", 32'(tx), 32'd1);
    ok = 1'b1;
  endtask

  task automatic wait_done(input int limit);
    int c;
    c = 0;
    while (tx_done_tick !== 1'b1 && c < limit) begin
      @(negedge clk);
      c++;
    end
    check("done_seen", 32'(tx_done_tick === 1'b1), 32'd1);
  endtask

  task automatic rx_and_score(input int bit_clk, input string tag);
    logic [7:0] d, e;
    logic       p;
    bit         ok;
    recv_frame(bit_clk, d, p, ok);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    if (ok) begin
      check(tag, 32'(d), 32'(e));
`ifdef UART_TX_PARITY_EN
      check({tag, "_parity"}, 32'(p), 32'(^e));
`endif
    end
  endtask

  initial begin
    int base, k, bad, g, cw;
    logic [7:0] tab [6];
    tab = '{8'h7E, 8'hFF, 8'h81, 8'hAA, 8'h55, 8'h33};

    // reset and quiet idle
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_empty", 32'(tx_empty), 32'd1);
    check("rst_full", 32'(tx_full), 32'd0);
    check("rst_done", 32'(tx_done_tick), 32'd0);
    reset = 1'b1;
    bad = 0;
    repeat (2000) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_done_tick !== 1'b0 || tx_empty !== 1'b1 || tx_full !== 1'b0) bad++;
    end
    check("idle_quiet", 32'(bad), 32'd0);

    // single byte
    dvsr = 11'd40;
    base = done_cnt;
    @(negedge clk);
    wr_uart = 1'b1;
    w_data  = 8'h7E;
    exp_q.push_back(8'h7E);
    @(negedge clk);
    wr_uart = 1'b0;
    check("empty_after_push", 32'(tx_empty), 32'd0);
    k = 1;
    while (tx !== 1'b0 && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("start_latency", 32'(k), 32'd3);
    rx_and_score(16 * 41, "single_data");
    wait_done(2 * 16 * 41);
    @(negedge clk);
    check("done_width", 32'(tx_done_tick), 32'd0);
    repeat (2) @(negedge clk);
    check("single_done_cnt", 32'(done_cnt - base), 32'd1);
    check("single_empty", 32'(tx_empty), 32'd1);

    // FIFO fill with one dropped write, back-to-back frames
    dvsr = 11'd4;
    base = done_cnt;
    fork
      begin
        @(negedge clk);
        wr_uart = 1'b1;
        w_data  = tab[0];
        for (int i = 0; i < 6; i++) begin
          if (i < 5) exp_q.push_back(tab[i]);
          @(negedge clk);
          if (i == 3) check("full_before_55", 32'(tx_full), 32'd0);
          if (i == 4) check("full_after_55", 32'(tx_full), 32'd1);
          if (i == 5) check("full_after_drop", 32'(tx_full), 32'd1);
          if (i < 5) w_data = tab[i+1];
          else       wr_uart = 1'b0;
        end
      end
      begin
        for (int f = 0; f < 5; f++) begin
          rx_and_score(80, "fill_data");
          wait_done(200);
          if (f < 4) begin
            g = 0;
            while (tx !== 1'b0 && g < 10) begin
              @(negedge clk);
              g++;
            end
            check("frame_gap", 32'(g), 32'd2);
          end
        end
      end
    join
    repeat (3) @(negedge clk);
    check("fill_done_cnt", 32'(done_cnt - base), 32'd5);
    check("fill_empty", 32'(tx_empty), 32'd1);
    bad = 0;
    repeat (1500) begin
      @(negedge clk);
      if (tx !== 1'b1) bad++;
    end
    check("no_dropped_frame", 32'(bad), 32'd0);

    // reset in the 4th data bit aborts the frame and drops the queue
    dvsr = 11'd10;
    base = done_cnt;
    @(negedge clk);
    wr_uart = 1'b1;
    w_data  = 8'hA5;
    @(negedge clk);
    w_data  = 8'h3C;
    @(negedge clk);
    wr_uart = 1'b0;
    k = 0;
    while (tx !== 1'b0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    repeat (88 + 4 * 176) @(negedge clk);
    check("pre_reset_bit3", 32'(tx), 32'd0);
    reset = 1'b0;
    #1;
    check("midrst_tx", 32'(tx), 32'd1);
    check("midrst_empty", 32'(tx_empty), 32'd1);
    check("midrst_full", 32'(tx_full), 32'd0);
    check("midrst_done", 32'(tx_done_tick), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    bad = 0;
    repeat (3000) begin
      @(negedge clk);
      if (tx !== 1'b1) bad++;
    end
    check("midrst_quiet", 32'(bad), 32'd0);
    check("midrst_done_cnt", 32'(done_cnt - base), 32'd0);

    // dvsr=0: a tick every clk
    dvsr = 11'd0;
    @(negedge clk);
    wr_uart = 1'b1;
    w_data  = 8'h81;
    exp_q.push_back(8'h81);
    @(negedge clk);
    wr_uart = 1'b0;
    cw = cycle_cnt;
    rx_and_score(16, "fast_data");
    wait_done(60);
`ifdef UART_TX_PARITY_EN
    check("fast_done_latency", 32'(cycle_cnt - cw), 32'd177);
`else
    check("fast_done_latency", 32'(cycle_cnt - cw), 32'd161);
`endif

`ifdef UART_TX_PARITY_EN
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      wr_uart = 1'b1;
      w_data  = (i == 0) ? 8'h07 : 8'h03;
      exp_q.push_back(w_data);
      @(negedge clk);
      wr_uart = 1'b0;
      rx_and_score(16, "par_data");
      wait_done(60);
    end
`endif

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
